// File: rtl/matriz_carregador_pkg.sv
// Shared constants, state encoding and packed-offset helper for the matrix loader.
// Optional feature macro: MATRIZ_CARREGADOR_TRANSPOSE_EN (column-major input stream).
package matriz_pkg;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    localparam logic [2:0] SIZE_MIN = 3'd2;
    localparam logic [2:0] SIZE_MAX = 3'd5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bit offset of element (i,j) inside the packed 5x5 vector; rows are 40 bits apart.
    function automatic logic [7:0] off(input logic [2:0] i, input logic [2:0] j);
        return ({5'd0, i} * 8'd40) + ({5'd0, j} * 8'd8);
    endfunction

endpackage

// File: rtl/matriz_carregador_if.sv
// Element stream handshake and packed-matrix result bus of the matrix loader.
// Optional feature macro: MATRIZ_CARREGADOR_TRANSPOSE_EN (does not change this bus).
interface matriz_carregador_if;
    import matriz_pkg::*;

    logic              start;
    logic [2:0]        size;
    logic [ELEM_W-1:0] elem_in;
    logic              elem_valid;
    logic              elem_ready;
    logic [MAT_W-1:0]  matriz_out;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, size, elem_in, elem_valid,
        input  elem_ready, matriz_out, busy, done, err
    );

    modport slave (
        input  start, size, elem_in, elem_valid,
        output elem_ready, matriz_out, busy, done, err
    );

endinterface

// File: rtl/matriz_carregador_idx_counter.sv
// 2-D row/col write-position counter wrapping at N-1.
// MATRIZ_CARREGADOR_TRANSPOSE_EN defined: row is the fast index (column-major stream).
module matriz_idx_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic [2:0] n,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [2:0] w_nm1;

    assign w_nm1 = n - 3'd1;
    assign row   = r_row;
    assign col   = r_col;
    assign last  = (r_row == w_nm1) && (r_col == w_nm1);

    // Position advance on each accepted element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= 3'd0;
            r_col <= 3'd0;
        end else if (clear) begin
            r_row <= 3'd0;
            r_col <= 3'd0;
        end else if (step) begin
`ifdef MATRIZ_CARREGADOR_TRANSPOSE_EN
            if (r_row == w_nm1) begin
                r_row <= 3'd0;
                r_col <= r_col + 3'd1;
            end else begin
                r_row <= r_row + 3'd1;
            end
`else
            if (r_col == w_nm1) begin
                r_col <= 3'd0;
                r_row <= r_row + 3'd1;
            end else begin
                r_col <= r_col + 3'd1;
            end
`endif
        end
    end

endmodule

// File: rtl/matriz_carregador.sv
// Serial-to-packed square matrix loader (N = 2..5) producing a zero-padded 5x5 packed vector.
// Optional feature macro: MATRIZ_CARREGADOR_TRANSPOSE_EN (handled in matriz_idx_counter).
module matriz_carregador
    import matriz_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    matriz_carregador_if.slave  bus
);

    state_t           r_state;
    logic [2:0]       r_n;
    logic [MAT_W-1:0] r_buf;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic       w_size_ok;
    logic       w_hs;
    logic       w_clear;
    logic [2:0] w_row;
    logic [2:0] w_col;
    logic       w_last;

    assign w_size_ok = (bus.size >= SIZE_MIN) && (bus.size <= SIZE_MAX);
    assign w_hs      = r_ready && bus.elem_valid;
    assign w_clear   = (r_state == ST_IDLE) && bus.start && w_size_ok;

    matriz_idx_counter u_idx (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .step  (w_hs),
        .n     (r_n),
        .row   (w_row),
        .col   (w_col),
        .last  (w_last)
    );

    // Load sequencing, buffer writes and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_n     <= 3'd0;
            r_buf   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start && w_size_ok) begin
                        r_n     <= bus.size;
                        r_buf   <= '0;
                        r_state <= ST_LOAD;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                    end else begin
                        r_err <= bus.start;
                    end
                end
                ST_LOAD: begin
                    r_err <= 1'b0;
                    if (w_hs) begin
                        r_buf[off(w_row, w_col) +: ELEM_W] <= bus.elem_in;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.elem_ready = r_ready;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.matriz_out = r_buf;

endmodule

// File: tb/tb_matriz_carregador.sv
// Randomized self-checking bench for matriz_carregador against a stream-level reference model.
// Honors MATRIZ_CARREGADOR_TRANSPOSE_EN when the build defines it.
module tb_matriz_carregador;

    logic clk;
    logic reset;
    matriz_carregador_if bus();

    matriz_carregador dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: matrix contents plus phase of the current load
    logic [7:0] m_mat [25];
    bit         m_load;
    bit         m_done;
    bit         m_err;
    int         m_n;
    int         m_k;
    logic [7:0] stream [25];

    function automatic logic [199:0] m_pack();
        logic [199:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v[i*8 +: 8] = m_mat[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 25; i++) m_mat[i] = 8'h00;
        m_load = 1'b0; m_done = 1'b0; m_err = 1'b0; m_n = 0; m_k = 0;
    endtask

    task automatic model_update();
        int r;
        int c;
        if (reset) begin
            model_clear();
        end else begin
            m_err = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_load) begin
                if (bus.elem_valid) begin
`ifdef MATRIZ_CARREGADOR_TRANSPOSE_EN
                    c = m_k / m_n; r = m_k % m_n;
`else
                    r = m_k / m_n; c = m_k % m_n;
`endif
                    m_mat[r*5 + c] = bus.elem_in;
                    m_k++;
                    if (m_k == m_n * m_n) begin
                        m_load = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (bus.start) begin
                if (bus.size >= 3'd2 && bus.size <= 3'd5) begin
                    m_load = 1'b1; m_n = int'(bus.size); m_k = 0;
                    for (int i = 0; i < 25; i++) m_mat[i] = 8'h00;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("elem_ready", 200'(bus.elem_ready), 200'(m_load));
        check("busy", 200'(bus.busy), 200'(m_load));
        check("done", 200'(bus.done), 200'(m_done));
        check("err", 200'(bus.err), 200'(m_err));
        check("matriz_out", bus.matriz_out, m_pack());
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_load(input int n, input bit rnd_valid, input int stall_after,
                            input int stall_len, input int abort_after,
                            input bit start_mid, input bit start_in_done, output int lat);
        int idx;
        int st;
        int cyc;
        bit hs;
        idx = 0; st = 0;
        bus.start = 1'b1; bus.size = 3'(n);
        step();
        cyc = 1;
        bus.start = 1'b0;
        while (!m_done && cyc < 400) begin
            if (idx == abort_after) break;
            if (idx == stall_after && st < stall_len) begin
                bus.elem_valid = 1'b0; st++;
            end else if (rnd_valid) begin
                bus.elem_valid = ($urandom_range(0, 3) != 0);
            end else begin
                bus.elem_valid = 1'b1;
            end
            bus.elem_in = stream[idx];
            bus.start   = start_mid && (idx == 2);
            bus.size    = 3'd3;
            hs = m_load && bus.elem_valid;
            step();
            cyc++;
            if (hs) idx++;
        end
        bus.start = 1'b0;
        bus.elem_valid = 1'b0;
        lat = cyc;
        if (abort_after < 0) begin
            if (!m_done) begin
                n_checks++; n_err++;
                $display("FAIL load_timeout: got no done expected done within 400 cycles");
            end else begin
                check("done_at_end", 200'(bus.done), 200'd1);
                check("ready_in_done", 200'(bus.elem_ready), 200'd0);
                if (start_in_done) begin
                    bus.start = 1'b1; bus.size = 3'd3;
                    step();
                    bus.start = 1'b0;
                    check("start_in_done_ignored", 200'(bus.elem_ready), 200'd0);
                end
            end
        end
    endtask

    initial begin
        int lat;
        int n;
        reset = 1'b1;
        bus.start = 1'b0; bus.size = 3'd0; bus.elem_in = 8'h00; bus.elem_valid = 1'b0;
        model_clear();
        step(); step();
        check("reset_matriz", bus.matriz_out, 200'd0);
        check("reset_ready", 200'(bus.elem_ready), 200'd0);
        reset = 1'b0;
        step();

        // N=3, stream 1..9
        for (int i = 0; i < 25; i++) stream[i] = 8'(i + 1);
        run_load(3, 1'b0, -1, 0, -1, 1'b0, 1'b0, lat);
        check("n3_latency", 200'(lat), 200'd10);
`ifdef MATRIZ_CARREGADOR_TRANSPOSE_EN
        check("n3_e00", 200'(bus.matriz_out[7:0]), 200'd1);
        check("n3_e10", 200'(bus.matriz_out[47:40]), 200'd2);
        check("n3_e01", 200'(bus.matriz_out[15:8]), 200'd4);
`else
        check("n3_e00", 200'(bus.matriz_out[7:0]), 200'd1);
        check("n3_e01", 200'(bus.matriz_out[15:8]), 200'd2);
        check("n3_e02", 200'(bus.matriz_out[23:16]), 200'd3);
        check("n3_e10", 200'(bus.matriz_out[47:40]), 200'd4);
`endif
        check("n3_e22", 200'(bus.matriz_out[103:96]), 200'd9);
        check("n3_pad_zero", 200'(bus.matriz_out[199:104]), 200'd0);
        check("n3_model_pin", m_pack(), bus.matriz_out);
        step();

        // N=5, 0x01..0x19, 3-cycle stall after element 7
        run_load(5, 1'b0, 7, 3, -1, 1'b0, 1'b0, lat);
        check("n5_latency", 200'(lat), 200'd29);
        check("n5_e44", 200'(bus.matriz_out[199:192]), 200'h19);
        step();

        // invalid size 6
        bus.start = 1'b1; bus.size = 3'd6;
        step();
        bus.start = 1'b0;
        check("err_pulse", 200'(bus.err), 200'd1);
        check("err_ready_low", 200'(bus.elem_ready), 200'd0);
        step();
        check("err_one_cycle", 200'(bus.err), 200'd0);
        check("err_matriz_kept", 200'(bus.matriz_out[199:192]), 200'h19);

        // N=4 aborted by reset after element 5, then N=2 load
        run_load(4, 1'b0, -1, 0, 5, 1'b0, 1'b0, lat);
        reset = 1'b1;
        model_clear();
        #1;
        check("rst_mid_matriz", bus.matriz_out, 200'd0);
        check("rst_mid_busy", 200'(bus.busy), 200'd0);
        step(); step();
        reset = 1'b0;
        step();
        check("rst_after_matriz", bus.matriz_out, 200'd0);
        stream[0] = 8'hAA; stream[1] = 8'hBB; stream[2] = 8'hCC; stream[3] = 8'hDD;
        run_load(2, 1'b0, -1, 0, -1, 1'b0, 1'b0, lat);
        check("n2_latency", 200'(lat), 200'd5);
        check("n2_e00", 200'(bus.matriz_out[7:0]), 200'hAA);
`ifdef MATRIZ_CARREGADOR_TRANSPOSE_EN
        check("n2_e10", 200'(bus.matriz_out[47:40]), 200'hBB);
        check("n2_e01", 200'(bus.matriz_out[15:8]), 200'hCC);
`else
        check("n2_e01", 200'(bus.matriz_out[15:8]), 200'hBB);
        check("n2_e10", 200'(bus.matriz_out[47:40]), 200'hCC);
`endif
        check("n2_e11", 200'(bus.matriz_out[55:48]), 200'hDD);
        step();

        // start during LOAD and in the DONE cycle
        for (int i = 0; i < 25; i++) stream[i] = 8'(8'h40 + i);
        run_load(4, 1'b0, -1, 0, -1, 1'b1, 1'b1, lat);
        check("start_ignored_latency", 200'(lat), 200'd17);
        step();

        // randomized loads and invalid starts
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 7);
            for (int i = 0; i < 25; i++) stream[i] = 8'($urandom);
            if (n < 2 || n > 5) begin
                bus.start = 1'b1; bus.size = 3'(n);
                step();
                bus.start = 1'b0;
                step();
            end else begin
                run_load(n, 1'b1, -1, 0, -1, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), lat);
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
